// File: rtl/game_pkg.sv
// game_pkg: state encodings and active-low 7-segment patterns for the
// raccoon/traffic game. The VGA overlay imports this package as well.
// Segment bit order is {G,F,E,D,C,B,A}, and 0 lights a segment.
package game_pkg;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_HIT       = 2'd1,
    ST_LEVEL_UP  = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/game_state_ctrl_seg7_decoder.sv
// seg7_decoder: combinational digit to active-low 7-segment decoder.
//   i_Digit : 4-bit digit; values above 9 blank the display
//   o_Seg   : segments {G,F,E,D,C,B,A}, active low
module seg7_decoder
  import game_pkg::*;
(
  input  logic [3:0] i_Digit,
  output logic [6:0] o_Seg
);

  always_comb begin
    o_Seg = seg_encode(i_Digit);
  end

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: collision, lives, level and score-display control for
// the raccoon/traffic game, generalised to NUM_CARS lanes.
//   i_Clk, i_Reset      : clock, asynchronous active-high reset
//   i_Restart           : synchronous restart request (level-sensitive)
//   i_Frame_Tick        : one-cycle pulse per video frame
//   i_Player_X/Y        : player top-left corner
//   i_Car_X/Y           : car k at bits [k*COORD_W +: COORD_W]
//   o_Level, o_Lives    : current level (1..MAX_LEVEL), remaining lives
//   o_State             : PLAY=0, HIT=1, LEVEL_UP=2, GAME_OVER=3
//   o_Collision         : any-car overlap, sampled on frame ticks
//   o_Player_Reset      : one-cycle pulse to send the player home
//   o_Seg_Units/Tens    : registered active-low level digits
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int NUM_CARS    = 2,
  parameter int COORD_W     = 10,
  parameter int PLAYER_W    = 32,
  parameter int PLAYER_H    = 32,
  parameter int CAR_W       = 32,
  parameter int CAR_H       = 32,
  parameter int START_LIVES = 3,
  parameter int MAX_LEVEL   = 9,
  parameter int GOAL_Y      = 0,
  parameter int HOLD_CYC    = 25_000_000
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Restart,
  input  logic                        i_Frame_Tick,
  input  logic [COORD_W-1:0]          i_Player_X,
  input  logic [COORD_W-1:0]          i_Player_Y,
  input  logic [NUM_CARS*COORD_W-1:0] i_Car_X,
  input  logic [NUM_CARS*COORD_W-1:0] i_Car_Y,
  output logic [3:0]                  o_Level,
  output logic [2:0]                  o_Lives,
  output logic [1:0]                  o_State,
  output logic                        o_Collision,
  output logic                        o_Player_Reset,
  output logic [6:0]                  o_Seg_Units,
  output logic [6:0]                  o_Seg_Tens
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int SW    = COORD_W + 1;

  state_t            state_q, state_d;
  logic [3:0]        level_q, level_d;
  logic [2:0]        lives_q, lives_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              preset_q, preset_d;
  logic              coll_q, coll_d;
  logic [6:0]        seg_u_q, seg_t_q, seg_u_d, seg_t_d;
  logic [3:0]        units, tens;

  // Overlap per car; one extra bit keeps every sum from wrapping.
  logic [NUM_CARS-1:0] hit_vec;
  logic                hit_any;
  logic [SW-1:0]       px, py;
  logic                goal;

  assign px = {1'b0, i_Player_X};
  assign py = {1'b0, i_Player_Y};

  for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
    logic [SW-1:0] cx, cy;
    assign cx = {1'b0, i_Car_X[k*COORD_W +: COORD_W]};
    assign cy = {1'b0, i_Car_Y[k*COORD_W +: COORD_W]};
    assign hit_vec[k] = (px < cx + SW'(CAR_W))    && (px + SW'(PLAYER_W) > cx) &&
                        (py < cy + SW'(CAR_H))    && (py + SW'(PLAYER_H) > cy);
  end

  assign hit_any = |hit_vec;
  assign goal    = (i_Player_Y <= COORD_W'(GOAL_Y));

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    lives_d  = lives_q;
    cnt_d    = cnt_q;
    preset_d = 1'b0;
    coll_d   = i_Frame_Tick ? hit_any : coll_q;

    if (i_Restart) begin
      state_d  = ST_PLAY;
      level_d  = 4'd1;
      lives_d  = 3'(START_LIVES);
      cnt_d    = '0;
      preset_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if (i_Frame_Tick) begin
            if (hit_any) begin
              lives_d  = lives_q - 3'd1;
              preset_d = 1'b1;
              if (lives_q == 3'd1) begin
                state_d = ST_GAME_OVER;
              end else begin
                state_d = ST_HIT;
                cnt_d   = CNT_W'(HOLD_CYC - 1);
              end
            end else if (goal) begin
              level_d  = (level_q == 4'(MAX_LEVEL)) ? 4'd1 : level_q + 4'd1;
              preset_d = 1'b1;
              state_d  = ST_LEVEL_UP;
            end
          end
        end
        // Counter is loaded with HOLD_CYC-1 and the exit happens on the
        // cycle that sees zero, giving exactly HOLD_CYC cycles in HIT.
        ST_HIT: begin
          if (cnt_q == '0) state_d = ST_PLAY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_LEVEL_UP: begin
          if (i_Frame_Tick) state_d = ST_PLAY;
        end
        ST_GAME_OVER: begin
        end
      endcase
    end
  end

  // Compare-and-subtract split; level never exceeds 15.
  always_comb begin
    if (level_q >= 4'd10) begin
      units = level_q - 4'd10;
      tens  = 4'd1;
    end else begin
      units = level_q;
      tens  = 4'd0;
    end
  end

  seg7_decoder u_seg_units (.i_Digit(units), .o_Seg(seg_u_d));
  seg7_decoder u_seg_tens  (.i_Digit(tens),  .o_Seg(seg_t_d));

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= ST_PLAY;
      level_q  <= 4'd1;
      lives_q  <= 3'(START_LIVES);
      cnt_q    <= '0;
      preset_q <= 1'b0;
      coll_q   <= 1'b0;
      seg_u_q  <= SEG_1;
      seg_t_q  <= SEG_0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
      preset_q <= preset_d;
      coll_q   <= coll_d;
      seg_u_q  <= seg_u_d;
      seg_t_q  <= seg_t_d;
    end
  end

  assign o_Level        = level_q;
  assign o_Lives        = lives_q;
  assign o_State        = state_q;
  assign o_Collision    = coll_q;
  assign o_Player_Reset = preset_q;
  assign o_Seg_Units    = seg_u_q;
  assign o_Seg_Tens     = seg_t_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

  localparam int NC = 3;
  localparam int CW = 10;

  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  logic i_Restart = 1'b0;
  logic i_Frame_Tick = 1'b0;
  logic [CW-1:0] px = 10'd300, py = 10'd300;
  logic [NC*CW-1:0] car_x = '0, car_y = '0;

  logic [3:0] a_level, b_level;
  logic [2:0] a_lives, b_lives;
  logic [1:0] a_state, b_state;
  logic       a_coll, b_coll, a_preset, b_preset;
  logic [6:0] a_su, a_st, b_su, b_st;

  always #5 i_Clk = ~i_Clk;

  game_state_ctrl #(.NUM_CARS(NC), .COORD_W(CW), .MAX_LEVEL(9), .HOLD_CYC(4)) dut_a (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Restart(i_Restart), .i_Frame_Tick(i_Frame_Tick),
    .i_Player_X(px), .i_Player_Y(py), .i_Car_X(car_x), .i_Car_Y(car_y),
    .o_Level(a_level), .o_Lives(a_lives), .o_State(a_state), .o_Collision(a_coll),
    .o_Player_Reset(a_preset), .o_Seg_Units(a_su), .o_Seg_Tens(a_st));

  game_state_ctrl #(.NUM_CARS(NC), .COORD_W(CW), .MAX_LEVEL(12), .HOLD_CYC(4)) dut_b (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Restart(i_Restart), .i_Frame_Tick(i_Frame_Tick),
    .i_Player_X(px), .i_Player_Y(py), .i_Car_X(car_x), .i_Car_Y(car_y),
    .o_Level(b_level), .o_Lives(b_lives), .o_State(b_state), .o_Collision(b_coll),
    .o_Player_Reset(b_preset), .o_Seg_Units(b_su), .o_Seg_Tens(b_st));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] state;
    logic [2:0] lives;
    logic [3:0] lvl_a, lvl_b;
    logic       coll, preset;
    logic [6:0] ua, ta, ub, tb;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0] m_state;
  logic [2:0] m_lives;
  logic [3:0] m_lvl_a, m_lvl_b;
  int         m_cnt;
  logic       m_coll;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      9: return 7'b0010000; default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit ovl();
    bit r = 0;
    for (int k = 0; k < NC; k++) begin
      int cx = int'(car_x[k*CW +: CW]);
      int cy = int'(car_y[k*CW +: CW]);
      if (int'(px) < cx + 32 && int'(px) + 32 > cx &&
          int'(py) < cy + 32 && int'(py) + 32 > cy) r = 1;
    end
    return r;
  endfunction

  task automatic set_car(input int k, input int x, input int y);
    car_x[k*CW +: CW] = CW'(x);
    car_y[k*CW +: CW] = CW'(y);
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_lives = 3'd3; m_lvl_a = 4'd1; m_lvl_b = 4'd1;
    m_cnt = 0; m_coll = 1'b0;
  endtask

  task automatic model_step(input bit tick, input bit rs);
    exp_t e;
    bit hit = ovl();
    bit goal = (py == 0);
    e.ua = seg_of(int'(m_lvl_a) % 10); e.ta = seg_of(int'(m_lvl_a) / 10);
    e.ub = seg_of(int'(m_lvl_b) % 10); e.tb = seg_of(int'(m_lvl_b) / 10);
    e.preset = 1'b0;
    if (tick) m_coll = hit;
    if (rs) begin
      m_state = 2'd0; m_lives = 3'd3; m_lvl_a = 4'd1; m_lvl_b = 4'd1;
      m_cnt = 0; e.preset = 1'b1;
    end else begin
      case (m_state)
        2'd0: if (tick) begin
          if (hit) begin
            m_lives = m_lives - 3'd1; e.preset = 1'b1;
            if (m_lives == 3'd0) m_state = 2'd3;
            else begin m_state = 2'd1; m_cnt = 3; end
          end else if (goal) begin
            m_lvl_a = (m_lvl_a == 4'd9)  ? 4'd1 : m_lvl_a + 4'd1;
            m_lvl_b = (m_lvl_b == 4'd12) ? 4'd1 : m_lvl_b + 4'd1;
            e.preset = 1'b1; m_state = 2'd2;
          end
        end
        2'd1: if (m_cnt == 0) m_state = 2'd0; else m_cnt--;
        2'd2: if (tick) m_state = 2'd0;
        default: ;
      endcase
    end
    e.state = m_state; e.lives = m_lives; e.lvl_a = m_lvl_a; e.lvl_b = m_lvl_b;
    e.coll = m_coll;
    sb.push_back(e);
  endtask

  // One clock: drive, predict, clock, then pop the prediction and compare.
  task automatic cycle(input bit tick, input bit rs);
    exp_t e;
    i_Frame_Tick = tick; i_Restart = rs;
    model_step(tick, rs);
    @(posedge i_Clk); #1;
    i_Frame_Tick = 1'b0; i_Restart = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard: queue empty, got nothing, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (a_state !== e.state) begin errors++; $display("FAIL state: got %0d expected %0d", a_state, e.state); end
    checks++;
    if (b_state !== e.state) begin errors++; $display("FAIL state_b: got %0d expected %0d", b_state, e.state); end
    checks++;
    if (a_lives !== e.lives) begin errors++; $display("FAIL lives: got %0d expected %0d", a_lives, e.lives); end
    checks++;
    if (b_lives !== e.lives) begin errors++; $display("FAIL lives_b: got %0d expected %0d", b_lives, e.lives); end
    checks++;
    if (a_level !== e.lvl_a) begin errors++; $display("FAIL level_a: got %0d expected %0d", a_level, e.lvl_a); end
    checks++;
    if (b_level !== e.lvl_b) begin errors++; $display("FAIL level_b: got %0d expected %0d", b_level, e.lvl_b); end
    checks++;
    if (a_coll !== e.coll) begin errors++; $display("FAIL collision: got %0b expected %0b", a_coll, e.coll); end
    checks++;
    if (a_preset !== e.preset || b_preset !== e.preset) begin
      errors++; $display("FAIL player_reset: got %0b/%0b expected %0b", a_preset, b_preset, e.preset);
    end
    checks++;
    if (a_su !== e.ua || a_st !== e.ta) begin
      errors++; $display("FAIL seg_a: got %b/%b expected %b/%b", a_st, a_su, e.ta, e.ua);
    end
    checks++;
    if (b_su !== e.ub || b_st !== e.tb) begin
      errors++; $display("FAIL seg_b: got %b/%b expected %b/%b", b_st, b_su, e.tb, e.ub);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic far_away();
    px = 10'd300; py = 10'd300;
    set_car(0, 600, 600); set_car(1, 700, 700); set_car(2, 800, 800);
  endtask

  task automatic test_reset();
    far_away();
    i_Reset = 1'b1;
    repeat (2) @(posedge i_Clk);
    #1;
    checks++;
    if (a_level !== 4'd1 || a_lives !== 3'd3 || a_state !== 2'd0 || a_coll !== 1'b0 ||
        a_preset !== 1'b0 || a_su !== 7'b1111001 || a_st !== 7'b1000000) begin
      errors++;
      $display("FAIL reset: got lvl=%0d lives=%0d st=%0d col=%0b pr=%0b seg=%b/%b expected 1 3 0 0 0 1000000/1111001",
               a_level, a_lives, a_state, a_coll, a_preset, a_st, a_su);
    end
    @(negedge i_Clk); i_Reset = 1'b0;
    model_reset();
    idle(2);
  endtask

  task automatic test_collision();
    int hit_cycles, pulses;
    set_car(2, 100, 100); px = 10'd110; py = 10'd110;
    cycle(1'b1, 1'b0);
    hit_cycles = (a_state == 2'd1) ? 1 : 0;
    pulses = int'(a_preset);
    cycle(1'b0, 1'b0); if (a_state == 2'd1) hit_cycles++; pulses += int'(a_preset);
    cycle(1'b1, 1'b0); if (a_state == 2'd1) hit_cycles++; pulses += int'(a_preset);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      pulses += int'(a_preset);
      if (a_state == 2'd1) hit_cycles++;
      else break;
    end
    checks++;
    if (hit_cycles != 4) begin errors++; $display("FAIL hit_duration: got %0d expected 4", hit_cycles); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL hit_pulses: got %0d expected 1", pulses); end
    checks++;
    if (a_lives !== 3'd2) begin errors++; $display("FAIL lives_after_hit: got %0d expected 2", a_lives); end
    far_away();
    cycle(1'b1, 1'b0);
  endtask

  task automatic test_goal();
    py = 10'd0;
    cycle(1'b1, 1'b0);
    checks++;
    if (a_level !== 4'd2 || a_state !== 2'd2) begin
      errors++; $display("FAIL goal: got lvl=%0d st=%0d expected lvl=2 st=2", a_level, a_state);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (a_level !== 4'd2 || a_state !== 2'd0) begin
      errors++; $display("FAIL level_up_exit: got lvl=%0d st=%0d expected lvl=2 st=0", a_level, a_state);
    end
    py = 10'd300;
    idle(1);
  endtask

  task automatic test_level_wrap_two_digit();
    cycle(1'b0, 1'b1);
    for (int g = 0; g < 8; g++) begin
      py = 10'd0;   cycle(1'b1, 1'b0);
      py = 10'd300; cycle(1'b1, 1'b0);
    end
    py = 10'd0; cycle(1'b1, 1'b0);
    checks++;
    if (a_level !== 4'd1 || b_level !== 4'd10) begin
      errors++; $display("FAIL level_wrap: got a=%0d b=%0d expected a=1 b=10", a_level, b_level);
    end
    checks++;
    if (b_st !== 7'b1000000) begin errors++; $display("FAIL seg_lag: got tens %b expected 1000000", b_st); end
    py = 10'd300; cycle(1'b1, 1'b0);
    checks++;
    if (b_st !== 7'b1111001 || b_su !== 7'b1000000) begin
      errors++; $display("FAIL two_digit: got %b/%b expected 1111001/1000000", b_st, b_su);
    end
    idle(1);
  endtask

  task automatic test_collision_and_goal();
    cycle(1'b0, 1'b1);
    set_car(0, 100, 0); px = 10'd110; py = 10'd0;
    cycle(1'b1, 1'b0);
    checks++;
    if (a_lives !== 3'd2 || a_level !== 4'd1 || a_state !== 2'd1) begin
      errors++; $display("FAIL hit_and_goal: got lives=%0d lvl=%0d st=%0d expected 2 1 1", a_lives, a_level, a_state);
    end
    far_away();
    idle(5);
  endtask

  task automatic test_game_over_restart();
    cycle(1'b0, 1'b1);
    for (int h = 0; h < 3; h++) begin
      set_car(2, 100, 100); px = 10'd110; py = 10'd110;
      cycle(1'b1, 1'b0);
      idle(5);
    end
    checks++;
    if (a_state !== 2'd3 || a_lives !== 3'd0) begin
      errors++; $display("FAIL game_over: got st=%0d lives=%0d expected 3 0", a_state, a_lives);
    end
    cycle(1'b1, 1'b0);
    py = 10'd0; far_away(); py = 10'd0;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    checks++;
    if (a_state !== 2'd0 || a_lives !== 3'd3 || a_level !== 4'd1 || a_preset !== 1'b1) begin
      errors++; $display("FAIL restart: got st=%0d lives=%0d lvl=%0d pr=%0b expected 0 3 1 1",
                         a_state, a_lives, a_level, a_preset);
    end
    far_away();
    idle(2);
  endtask

  task automatic test_reset_mid();
    py = 10'd0; cycle(1'b1, 1'b0);
    py = 10'd300; cycle(1'b1, 1'b0);
    set_car(1, 100, 100); px = 10'd110; py = 10'd110;
    cycle(1'b1, 1'b0);
    i_Reset = 1'b1; #1;
    checks++;
    if (a_level !== 4'd1 || a_lives !== 3'd3 || a_state !== 2'd0 || a_coll !== 1'b0 ||
        a_preset !== 1'b0 || a_su !== 7'b1111001 || a_st !== 7'b1000000) begin
      errors++; $display("FAIL reset_mid_hit: got lvl=%0d lives=%0d st=%0d col=%0b pr=%0b", a_level, a_lives,
                         a_state, a_coll, a_preset);
    end
    @(negedge i_Clk); i_Reset = 1'b0;
    model_reset();
    for (int h = 0; h < 3; h++) begin cycle(1'b1, 1'b0); idle(5); end
    i_Reset = 1'b1; #1;
    checks++;
    if (a_lives !== 3'd3 || a_state !== 2'd0 || a_coll !== 1'b0) begin
      errors++; $display("FAIL reset_mid_game_over: got lives=%0d st=%0d col=%0b expected 3 0 0",
                         a_lives, a_state, a_coll);
    end
    @(negedge i_Clk); i_Reset = 1'b0;
    model_reset();
    far_away();
    idle(3);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_collision();
    test_goal();
    test_level_wrap_two_digit();
    test_collision_and_goal();
    test_game_over_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
